// File: rtl/tag_rx_hop_ctrl.sv
// tag_rx_hop_ctrl: multi-hop tag RX sequencer.
// Swaps sync markers into the IQ stream and reports frame progress on GPIO.
module tag_rx_hop_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int CNT_WIDTH      = 18,
    parameter int NUM_HOPS       = 64,
    parameter int HOP_WIDTH      = 6,
    parameter int LOC_SYNC_LEN   = 8192,
    parameter int HOP_SYNC_LEN   = 24576,
    parameter int SCAN_SYNC_LEN  = 8192,
    parameter int HOP_RX_LEN     = 16384,
    parameter int IDLE_LIMIT     = 16384,
    parameter int SYNC_AMP       = 32000,
    parameter int SYNC_IN_BIT    = 2,
    parameter int SCAN_IN_BIT    = 6,
    parameter int SYNC_OUT_BIT   = 0,
    parameter int RX_OUT_BIT     = 4,
    parameter int HOP_OUT_BIT    = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     irx_in,
    input  logic [DATA_WIDTH-1:0]     qrx_in,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    output logic [DATA_WIDTH-1:0]     irx_out,
    output logic [DATA_WIDTH-1:0]     qrx_out,
    output logic                      rx_valid,
    output logic [1:0]                rx_state,
    output logic [HOP_WIDTH-1:0]      hop_idx,
    output logic [CNT_WIDTH-1:0]      phase_count,
    output logic                      frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOC   = 2'd1,
        ST_HSYNC = 2'd2,
        ST_HRX   = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LOC_LOAD  = CNT_WIDTH'(LOC_SYNC_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] HS_LOAD   = CNT_WIDTH'(HOP_SYNC_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] SCAN_LOAD = CNT_WIDTH'(SCAN_SYNC_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] RX_LOAD   = CNT_WIDTH'(HOP_RX_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] IDLE_LIM  = CNT_WIDTH'(IDLE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [HOP_WIDTH-1:0] HOP_LAST  = HOP_WIDTH'(NUM_HOPS - 1);
    localparam logic [HOP_WIDTH-1:0] HOP_ONE   = HOP_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] AMP_P    = DATA_WIDTH'(SYNC_AMP);
    localparam logic [DATA_WIDTH-1:0] AMP_N    = DATA_WIDTH'(-SYNC_AMP);
    localparam logic [GPIO_REG_WIDTH-1:0] DDR_MASK =
        (GPIO_REG_WIDTH'(1) << SYNC_OUT_BIT) |
        (GPIO_REG_WIDTH'(1) << RX_OUT_BIT)   |
        (GPIO_REG_WIDTH'(1) << HOP_OUT_BIT);

    logic [GPIO_REG_WIDTH-1:0] sync1_q;
    logic [GPIO_REG_WIDTH-1:0] sync2_q;
    logic                      sync3_q;
    logic [1:0]                fill_q;
    logic                      arm_q;
    logic                      edge_q;
    logic                      scan;
    logic                      unused_sync;

    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      phase_q, phase_d;
    logic [CNT_WIDTH-1:0]      idle_q, idle_d;
    logic [HOP_WIDTH-1:0]      hop_q, hop_d;
    logic                      rxv_q, rxv_d;
    logic                      fd_q, fd_d;
    logic                      tog_q, tog_d;
    logic [GPIO_REG_WIDTH-1:0] gpio_q, gpio_d;
    logic [DATA_WIDTH-1:0]     i_q, q_q;

    assign scan        = sync2_q[SCAN_IN_BIT];
    assign unused_sync = ^sync2_q;

    // Pin synchroniser; the edge detector arms only once the chain holds a
    // genuine low, so a pin already high when reset releases is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= 1'b0;
            fill_q  <= 2'd0;
            arm_q   <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= fp_gpio_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q[SYNC_IN_BIT];
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            if (fill_q == 2'd2 && !sync2_q[SYNC_IN_BIT]) begin
                arm_q <= 1'b1;
            end
            edge_q <= arm_q & sync2_q[SYNC_IN_BIT] & ~sync3_q;
        end
    end

    // Next-state decode; a sync edge overrides any terminal count.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idle_d  = idle_q;
        hop_d   = hop_q;
        rxv_d   = rxv_q;
        fd_d    = 1'b0;
        tog_d   = tog_q;
        if (edge_q) begin
            state_d = ST_LOC;
            phase_d = LOC_LOAD;
            hop_d   = '0;
            rxv_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (idle_q < IDLE_LIM) begin
                        idle_d = idle_q + CNT_ONE;
                    end else begin
                        rxv_d = 1'b0;
                    end
                end
                ST_LOC: begin
                    if (phase_q == '0) begin
                        state_d = ST_HSYNC;
                        phase_d = scan ? SCAN_LOAD : HS_LOAD;
                    end else begin
                        phase_d = phase_q - CNT_ONE;
                    end
                end
                ST_HSYNC: begin
                    if (phase_q == '0) begin
                        state_d = ST_HRX;
                        phase_d = RX_LOAD;
                    end else begin
                        phase_d = phase_q - CNT_ONE;
                    end
                end
                ST_HRX: begin
                    if (phase_q != '0) begin
                        phase_d = phase_q - CNT_ONE;
                    end else if (hop_q < HOP_LAST) begin
                        state_d = ST_HSYNC;
                        phase_d = scan ? SCAN_LOAD : HS_LOAD;
                        hop_d   = hop_q + HOP_ONE;
                        tog_d   = ~tog_q;
                    end else begin
                        state_d = ST_IDLE;
                        idle_d  = '0;
                        fd_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // GPIO image built from next state so it lands with the state update.
    always_comb begin
        gpio_d               = '0;
        gpio_d[SYNC_OUT_BIT] = (state_d == ST_LOC) || (state_d == ST_HSYNC);
        gpio_d[RX_OUT_BIT]   = rxv_d;
        gpio_d[HOP_OUT_BIT]  = tog_d;
    end

    // Sequencer state and its registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            idle_q  <= '0;
            hop_q   <= '0;
            rxv_q   <= 1'b0;
            fd_q    <= 1'b0;
            tog_q   <= 1'b0;
            gpio_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idle_q  <= idle_d;
            hop_q   <= hop_d;
            rxv_q   <= rxv_d;
            fd_q    <= fd_d;
            tog_q   <= tog_d;
            gpio_q  <= gpio_d;
        end
    end

    // IQ register: markers in sync phases, passthrough otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_q <= '0;
            q_q <= '0;
        end else begin
            unique case (state_q)
                ST_LOC: begin
                    i_q <= AMP_N;
                    q_q <= '0;
                end
                ST_HSYNC: begin
                    i_q <= AMP_P;
                    q_q <= '0;
                end
                default: begin
                    i_q <= irx_in;
                    q_q <= qrx_in;
                end
            endcase
        end
    end

    assign fp_gpio_out = gpio_q;
    assign fp_gpio_ddr = DDR_MASK;
    assign irx_out     = i_q;
    assign qrx_out     = q_q;
    assign rx_valid    = rxv_q;
    assign rx_state    = state_q;
    assign hop_idx     = hop_q;
    assign phase_count = phase_q;
    assign frame_done  = fd_q;

endmodule

// File: tb/tb_tag_rx_hop_ctrl.sv
// tb_tag_rx_hop_ctrl: scoreboard bench for tag_rx_hop_ctrl.
// Expected per-cycle traces are built from phase lengths and popped each cycle.
module tb_tag_rx_hop_ctrl;

    localparam int DW   = 16;
    localparam int GW   = 12;
    localparam int CW   = 8;
    localparam int HW   = 2;
    localparam int NH   = 3;
    localparam int LOC  = 4;
    localparam int HS   = 6;
    localparam int SS   = 3;
    localparam int HRX  = 5;
    localparam int IDL  = 10;
    localparam int AMP  = 32000;
    localparam int TRAIL = 30;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] hop;
        logic [7:0] ph;
        logic       fd;
        logic       rv;
        logic       tog;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] irx_in, qrx_in;
    logic [GW-1:0] fp_gpio_in;
    logic [GW-1:0] fp_gpio_out, fp_gpio_ddr;
    logic [DW-1:0] irx_out, qrx_out;
    logic          rx_valid;
    logic [1:0]    rx_state;
    logic [HW-1:0] hop_idx;
    logic [CW-1:0] phase_count;
    logic          frame_done;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   sync_pin = 0;
    bit   scan_pin = 0;
    bit   scan_drop_en = 0;
    logic [1:0] prev_st = 2'd0;

    tag_rx_hop_ctrl #(
        .DATA_WIDTH(DW), .GPIO_REG_WIDTH(GW), .CNT_WIDTH(CW),
        .NUM_HOPS(NH), .HOP_WIDTH(HW), .LOC_SYNC_LEN(LOC),
        .HOP_SYNC_LEN(HS), .SCAN_SYNC_LEN(SS), .HOP_RX_LEN(HRX),
        .IDLE_LIMIT(IDL), .SYNC_AMP(AMP), .SYNC_IN_BIT(2),
        .SCAN_IN_BIT(6), .SYNC_OUT_BIT(0), .RX_OUT_BIT(4),
        .HOP_OUT_BIT(8)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .irx_in(irx_in), .qrx_in(qrx_in),
        .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out),
        .fp_gpio_ddr(fp_gpio_ddr),
        .irx_out(irx_out), .qrx_out(qrx_out),
        .rx_valid(rx_valid), .rx_state(rx_state),
        .hop_idx(hop_idx), .phase_count(phase_count),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_rec(input int st, input int hop, input int ph,
                            input bit fd, input bit rv, input bit tog);
        exp_t e;
        e.st  = 2'(st);
        e.hop = 2'(hop);
        e.ph  = 8'(ph);
        e.fd  = fd;
        e.rv  = rv;
        e.tog = tog;
        q.push_back(e);
    endtask

    task automatic push_idle(input int n, input bit fd0, input bit rv,
                             input int hop, input bit tog);
        for (int i = 0; i < n; i++) begin
            push_rec(0, hop, 0, fd0 && (i == 0), rv && (i <= IDL), tog);
        end
    endtask

    task automatic push_frame(input bit [2:0] scan_h, input bit tog0);
        bit tog;
        int len;
        tog = tog0;
        for (int p = LOC - 1; p >= 0; p--) push_rec(1, 0, p, 0, 1, tog);
        for (int h = 0; h < NH; h++) begin
            len = scan_h[h] ? SS : HS;
            for (int p = len - 1; p >= 0; p--) push_rec(2, h, p, 0, 1, tog);
            for (int p = HRX - 1; p >= 0; p--) push_rec(3, h, p, 0, 1, tog);
            if (h < NH - 1) tog = ~tog;
        end
        push_idle(TRAIL, 1, 1, NH - 1, tog);
    endtask

    task automatic play_cycle();
        exp_t e;
        logic [DW-1:0] di, dq, ei, eq;
        logic [GW-1:0] eg;
        di = DW'($urandom);
        dq = DW'($urandom);
        irx_in = di;
        qrx_in = dq;
        fp_gpio_in = (GW'($urandom) & ~GW'(12'h044)) |
                     (GW'(sync_pin) << 2) | (GW'(scan_pin) << 6);
        @(posedge clk);
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL queue_empty t=%0t", $time);
            return;
        end
        e = q.pop_front();
        case (prev_st)
            2'd1: begin ei = DW'(-AMP); eq = '0; end
            2'd2: begin ei = DW'(AMP);  eq = '0; end
            default: begin ei = di; eq = dq; end
        endcase
        eg = '0;
        eg[0] = (e.st == 2'd1) || (e.st == 2'd2);
        eg[4] = e.rv;
        eg[8] = e.tog;
        checks++;
        if (rx_state !== e.st) begin
            errors++;
            $display("FAIL state t=%0t got %0d exp %0d", $time, rx_state, e.st);
        end
        checks++;
        if (hop_idx !== e.hop) begin
            errors++;
            $display("FAIL hop t=%0t got %0d exp %0d", $time, hop_idx, e.hop);
        end
        checks++;
        if (phase_count !== e.ph) begin
            errors++;
            $display("FAIL phase t=%0t got %0d exp %0d", $time, phase_count, e.ph);
        end
        checks++;
        if (frame_done !== e.fd) begin
            errors++;
            $display("FAIL frame_done t=%0t got %0b exp %0b", $time, frame_done, e.fd);
        end
        checks++;
        if (rx_valid !== e.rv) begin
            errors++;
            $display("FAIL rx_valid t=%0t got %0b exp %0b", $time, rx_valid, e.rv);
        end
        checks++;
        if (fp_gpio_out !== eg) begin
            errors++;
            $display("FAIL gpio t=%0t got %h exp %h", $time, fp_gpio_out, eg);
        end
        checks++;
        if (irx_out !== ei || qrx_out !== eq) begin
            errors++;
            $display("FAIL iq t=%0t got %h/%h exp %h/%h",
                     $time, irx_out, qrx_out, ei, eq);
        end
        prev_st = e.st;
        if (scan_drop_en && e.st == 2'd3 && e.hop == 2'd0 && e.ph == 8'd4) begin
            scan_pin = 0;
            scan_drop_en = 0;
        end
    endtask

    task automatic play_n(input int n);
        for (int i = 0; i < n; i++) play_cycle();
    endtask

    task automatic play_until_rec(input int st, input int hop, input int ph);
        int n;
        n = 0;
        while (q.size() > 0 && n < 200 &&
               !(q[0].st == 2'(st) && q[0].hop == 2'(hop) && q[0].ph == 8'(ph))) begin
            play_cycle();
            n++;
        end
        checks++;
        if (q.size() == 0 || n >= 200) begin
            errors++;
            $display("FAIL wait_rec st=%0d hop=%0d ph=%0d not reached", st, hop, ph);
        end
    endtask

    task automatic play_until_fd();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200 && !q[0].fd) begin
            play_cycle();
            n++;
        end
        checks++;
        if (q.size() == 0 || n >= 200) begin
            errors++;
            $display("FAIL wait_frame_end not reached");
        end
    endtask

    task automatic trigger(input bit [2:0] scan_h, input int hold);
        checks++;
        if (q.size() < 3) begin
            errors++;
            $display("FAIL trigger_queue got %0d exp >=3", q.size());
            return;
        end
        while (q.size() > 3) q.delete(q.size() - 1);
        push_frame(scan_h, q[2].tog);
        sync_pin = 1;
        play_n(hold);
        sync_pin = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        irx_in = '0;
        qrx_in = '0;
        fp_gpio_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_state, hop_idx, phase_count, rx_valid, frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_status got %0d/%0d/%0d/%0b/%0b exp 0",
                     rx_state, hop_idx, phase_count, rx_valid, frame_done);
        end
        checks++;
        if ({irx_out, qrx_out, fp_gpio_out} !== '0) begin
            errors++;
            $display("FAIL reset_io got %h/%h/%h exp 0", irx_out, qrx_out, fp_gpio_out);
        end
        checks++;
        if (fp_gpio_ddr !== 12'h111) begin
            errors++;
            $display("FAIL ddr got %h exp 111", fp_gpio_ddr);
        end
        @(negedge clk);
        reset_n = 1;
        prev_st = 2'd0;
        push_idle(8, 0, 0, 0, 0);
        play_n(5);
    endtask

    task automatic test_single_frame();
        scan_pin = 0;
        trigger(3'b000, 1);
        play_until_fd();
        play_n(3);
    endtask

    task automatic test_multihop_scan();
        scan_pin = 1;
        play_n(3);
        scan_drop_en = 1;
        trigger(3'b001, 10);
        play_until_fd();
        checks++;
        if (scan_drop_en !== 1'b0 || scan_pin !== 1'b0) begin
            errors++;
            $display("FAIL scan_drop got %0b exp 0", scan_drop_en);
        end
    endtask

    task automatic test_idle_keepalive();
        play_n(5);
        trigger(3'b000, 1);
        play_until_fd();
    endtask

    task automatic test_idle_timeout();
        play_n(16);
    endtask

    task automatic test_resync();
        trigger(3'b000, 1);
        play_until_rec(3, 1, 2);
        trigger(3'b000, 1);
        play_until_rec(2, 1, 4);
        trigger(3'b000, 1);
        play_until_fd();
        play_n(3);
    endtask

    task automatic test_reset_midframe();
        trigger(3'b000, 1);
        play_until_rec(2, 0, 3);
        play_n(2);
        #3;
        reset_n = 0;
        sync_pin = 1;
        #1;
        checks++;
        if ({rx_state, hop_idx, phase_count, rx_valid, frame_done} !== '0) begin
            errors++;
            $display("FAIL async_reset_status got %0d/%0d/%0d/%0b/%0b exp 0",
                     rx_state, hop_idx, phase_count, rx_valid, frame_done);
        end
        checks++;
        if ({irx_out, qrx_out, fp_gpio_out} !== '0) begin
            errors++;
            $display("FAIL async_reset_io got %h/%h/%h exp 0",
                     irx_out, qrx_out, fp_gpio_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rx_state !== 2'd0 || fp_gpio_out !== '0) begin
            errors++;
            $display("FAIL held_reset got %0d/%h exp 0/0", rx_state, fp_gpio_out);
        end
        #2;
        reset_n = 1;
        q.delete();
        push_idle(40, 0, 0, 0, 0);
        prev_st = 2'd0;
        play_n(10);
        sync_pin = 0;
        play_n(5);
        trigger(3'b000, 1);
        play_until_fd();
        play_n(3);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_multihop_scan();
        test_idle_keepalive();
        test_idle_timeout();
        test_resync();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
